// File: rtl/io_stress_test_ctrl.sv
// I/O stress test sequencer: waits for PLL lock, runs pattern generators, waits for
// checker alignment, soaks for RUN_CYC cycles counting per-link errors, reports verdict.
module io_stress_test_ctrl #(
  parameter int NUM_LINKS    = 4,
  parameter int CNT_W        = 16,
  parameter int SETTLE_CYC   = 16,
  parameter int SYNC_TIMEOUT = 1024,
  parameter int RUN_CYC      = 1000000
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       pll_lock,
  input  logic [NUM_LINKS-1:0]       link_sync,
  input  logic [NUM_LINKS-1:0]       link_err,
  output logic                       gen_en,
  output logic                       chk_en,
  output logic                       chk_clear,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       lock_lost,
  output logic [NUM_LINKS-1:0]       fail_mask,
  output logic [NUM_LINKS*CNT_W-1:0] err_cnt
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_CLEAR     = 3'd2;
  localparam logic [2:0] S_SETTLE    = 3'd3;
  localparam logic [2:0] S_WAIT_SYNC = 3'd4;
  localparam logic [2:0] S_RUN       = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(SYNC_TIMEOUT - 1);
  localparam logic [31:0] RUN_LAST     = 32'(RUN_CYC - 1);

  logic [2:0]                 r_state;
  logic [31:0]                r_cnt;
  logic                       r_gen_en;
  logic                       r_chk_en;
  logic                       r_chk_clear;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_pass;
  logic                       r_lock_lost;
  logic [NUM_LINKS-1:0]       r_fail_mask;
  logic [NUM_LINKS*CNT_W-1:0] r_err_cnt;

  logic [2:0]                 w_state_nxt;
  logic [31:0]                w_cnt_nxt;
  logic                       w_armed;
  logic                       w_sync_to;
  logic                       w_lost_nxt;
  logic [NUM_LINKS-1:0]       w_fail_nxt;
  logic [NUM_LINKS*CNT_W-1:0] w_err_nxt;

  assign w_armed   = (r_state == S_SETTLE) || (r_state == S_WAIT_SYNC) || (r_state == S_RUN);
  assign w_sync_to = (r_state == S_WAIT_SYNC) && pll_lock && !(&link_sync) &&
                     (r_cnt == TIMEOUT_LAST) && !abort;

  // Next-state decode; abort overrides everything, lock loss overrides normal progress.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      w_state_nxt = start ? S_WAIT_LOCK : S_IDLE;
      S_WAIT_LOCK: w_state_nxt = pll_lock ? S_CLEAR : S_WAIT_LOCK;
      S_CLEAR:     w_state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (!pll_lock)                 w_state_nxt = S_DONE;
        else if (r_cnt == SETTLE_LAST) w_state_nxt = S_WAIT_SYNC;
        else                           w_state_nxt = S_SETTLE;
      end
      S_WAIT_SYNC: begin
        if (!pll_lock)                  w_state_nxt = S_DONE;
        else if (&link_sync)            w_state_nxt = S_RUN;
        else if (r_cnt == TIMEOUT_LAST) w_state_nxt = S_DONE;
        else                            w_state_nxt = S_WAIT_SYNC;
      end
      S_RUN: begin
        if (!pll_lock)              w_state_nxt = S_DONE;
        else if (r_cnt == RUN_LAST) w_state_nxt = S_DONE;
        else                        w_state_nxt = S_RUN;
      end
      S_DONE:  w_state_nxt = start ? S_WAIT_LOCK : S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
    w_cnt_nxt = (w_state_nxt != r_state) ? 32'd0 : r_cnt + 32'd1;
  end

  // Result bookkeeping: cleared on CLEAR entry, errors only counted while soaking.
  always_comb begin
    w_lost_nxt = r_lock_lost;
    w_fail_nxt = r_fail_mask;
    w_err_nxt  = r_err_cnt;
    if (w_state_nxt == S_CLEAR) begin
      w_lost_nxt = 1'b0;
      w_fail_nxt = '0;
      w_err_nxt  = '0;
    end else begin
      if (w_armed && !pll_lock) begin
        w_lost_nxt = 1'b1;
      end else begin
        w_lost_nxt = r_lock_lost;
      end
      if (w_sync_to) begin
        w_fail_nxt = r_fail_mask | ~link_sync;
      end else begin
        w_fail_nxt = r_fail_mask;
      end
      for (int i = 0; i < NUM_LINKS; i++) begin
        if ((r_state == S_RUN) && link_err[i]) begin
          w_fail_nxt[i] = 1'b1;
          if (r_err_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
            w_err_nxt[i*CNT_W +: CNT_W] = r_err_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
          end else begin
            w_err_nxt[i*CNT_W +: CNT_W] = r_err_cnt[i*CNT_W +: CNT_W];
          end
        end else begin
          w_err_nxt[i*CNT_W +: CNT_W] = r_err_cnt[i*CNT_W +: CNT_W];
        end
      end
    end
  end

  // State, counters and registered outputs decoded from the state being entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= 32'd0;
      r_gen_en    <= 1'b0;
      r_chk_en    <= 1'b0;
      r_chk_clear <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_lock_lost <= 1'b0;
      r_fail_mask <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gen_en    <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_WAIT_SYNC) ||
                     (w_state_nxt == S_RUN);
      r_chk_en    <= (w_state_nxt == S_WAIT_SYNC) || (w_state_nxt == S_RUN);
      r_chk_clear <= (w_state_nxt == S_CLEAR);
      r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done      <= (w_state_nxt == S_DONE);
      r_pass      <= (w_state_nxt == S_DONE) && (w_fail_nxt == '0) && !w_lost_nxt;
      r_lock_lost <= w_lost_nxt;
      r_fail_mask <= w_fail_nxt;
      r_err_cnt   <= w_err_nxt;
    end
  end

  assign gen_en    = r_gen_en;
  assign chk_en    = r_chk_en;
  assign chk_clear = r_chk_clear;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign lock_lost = r_lock_lost;
  assign fail_mask = r_fail_mask;
  assign err_cnt   = r_err_cnt;

endmodule
